// File: rtl/alu_pkg.sv
// Shared constants for the RPN ALU divider path.
// Holds the state encoding, the division opcode, the default width and the error quotient.
package alu_pkg;
  localparam int          WIDTH    = 8;
  localparam logic [7:0]  ERR_QUOT = 8'hFF;
  localparam logic [2:0]  OP_DIV   = 3'b011;

  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_DIVIDE = 2'd1;
  localparam logic [1:0]  ST_DONE   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_DIVIDE = ST_DIVIDE,
    S_DONE   = ST_DONE
  } state_e;
endpackage

// File: rtl/div_passo.sv
// One restoring-division step: shift in the next dividend bit and conditionally subtract.
// Purely combinational; the sequencing lives in divisor_sequencial.
module div_passo #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             din_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_bit_o
);
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  // One spare bit above the WIDTH+1 remainder keeps the borrow visible even for 255/1.
  assign shifted = {rem_i, din_i};
  assign trial   = shifted - {2'b00, b_i};

  always_comb begin
    q_bit_o = ~trial[WIDTH+1];
    rem_o   = shifted[WIDTH:0];
    if (!trial[WIDTH+1]) rem_o = trial[WIDTH:0];
  end
endmodule

// File: rtl/divisor_sequencial.sv
// Multi-cycle unsigned restoring divider with a Start/Busy/Done handshake.
// state  | meaning
// IDLE   | waiting for Start; captures A/B, short-circuits B==0 to DONE
// DIVIDE | one quotient bit per clock, WIDTH cycles
// DONE   | Done pulse for one cycle, results valid
module divisor_sequencial
  import alu_pkg::*;
#(
  parameter int               WIDTH    = alu_pkg::WIDTH,
  parameter logic [WIDTH-1:0] ERR_QUOT = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             Busy,
  output logic             Done,
  output logic             Erro
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             erro_q, erro_d;

  logic [WIDTH:0]   rem_nxt;
  logic             q_bit;

  div_passo #(.WIDTH(WIDTH)) u_passo (
    .rem_i   (rem_q),
    .din_i   (dvd_q[WIDTH-1]),
    .b_i     (dsr_q),
    .rem_o   (rem_nxt),
    .q_bit_o (q_bit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      erro_q  <= erro_d;
    end
  end

  // Busy/Done are decided alongside the next state so they come straight out of flops.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    erro_d  = erro_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          dvd_d  = A;
          dsr_d  = B;
          erro_d = 1'b0;
          rem_d  = '0;
          cnt_d  = CNT_W'(WIDTH);
          if (B == '0) begin
            q_d     = ERR_QUOT;
            r_d     = A;
            erro_d  = 1'b1;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            busy_d  = 1'b1;
            state_d = S_DIVIDE;
          end
        end
      end
      S_DIVIDE: begin
        // Quotient bits shift in from the right as dividend bits leave on the left.
        dvd_d = {dvd_q[WIDTH-2:0], q_bit};
        rem_d = rem_nxt;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          q_d     = {dvd_q[WIDTH-2:0], q_bit};
          r_d     = rem_nxt[WIDTH-1:0];
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          busy_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign Q    = q_q;
  assign R    = r_q;
  assign Busy = busy_q;
  assign Done = done_q;
  assign Erro = erro_q;
endmodule

// File: tb/tb_divisor_sequencial.sv
// Directed bench for divisor_sequencial: cycle-exact Busy/Done timing and hand-computed Q/R/Erro.
// Cycle n is observed on the falling edge after rising edge n-1; Start is sampled at edge 0.
module tb_divisor_sequencial;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       Start;
  logic [7:0] A, B;
  logic [7:0] Q, R;
  logic       Busy, Done, Erro;

  int checks   = 0;
  int failures = 0;

  divisor_sequencial dut (
    .clk   (clk),
    .rst_n (rst_n),
    .Start (Start),
    .A     (A),
    .B     (B),
    .Q     (Q),
    .R     (R),
    .Busy  (Busy),
    .Done  (Done),
    .Erro  (Erro)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs one request and checks Busy/Done every cycle plus Q/R/Erro at each Done.
  // hold keeps Start high for back-to-back operations; repulse injects a second Start mid-run.
  task automatic run(input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] eq, input logic [7:0] er, input logic ee,
                     input int ncyc, input bit hold, input bit repulse);
    logic exp_busy, exp_done;
    int   done_cnt;
    done_cnt = 0;
    A = a; B = b; Start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      if (!hold && n == 1) Start = 1'b0;
      if (repulse && n == 4) begin A = 8'd50; B = 8'd5; Start = 1'b1; end
      if (repulse && n == 5) Start = 1'b0;
      if (b == 8'd0) begin
        exp_busy = 1'b0;
        exp_done = (n == 1);
      end else begin
        exp_busy = (hold || n <= 9) && (n % 10 >= 1) && (n % 10 <= 8);
        exp_done = (hold || n <= 9) && (n % 10 == 9);
      end
      check($sformatf("busy[%0d/%0d c%0d]", a, b, n), Busy, exp_busy);
      check($sformatf("done[%0d/%0d c%0d]", a, b, n), Done, exp_done);
      if (Done) done_cnt++;
      if (exp_done) begin
        check($sformatf("q[%0d/%0d c%0d]", a, b, n), Q, eq);
        check($sformatf("r[%0d/%0d c%0d]", a, b, n), R, er);
        check($sformatf("erro[%0d/%0d c%0d]", a, b, n), Erro, ee);
      end
    end
    Start = 1'b0;
    check($sformatf("q_hold[%0d/%0d]", a, b), Q, eq);
    check($sformatf("r_hold[%0d/%0d]", a, b), R, er);
    check($sformatf("erro_hold[%0d/%0d]", a, b), Erro, ee);
    if (!hold) check($sformatf("done_count[%0d/%0d]", a, b), done_cnt, 1);
  endtask

  initial begin
    rst_n = 1'b0; Start = 1'b0; A = 8'd0; B = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_q", Q, 0);
    check("rst_r", R, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_erro", Erro, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run(8'd200, 8'd7, 8'd28,  8'd4, 1'b0, 12, 1'b0, 1'b0);
    run(8'd5,   8'd0, 8'hFF,  8'd5, 1'b1, 4,  1'b0, 1'b0);
    run(8'd9,   8'd3, 8'd3,   8'd0, 1'b0, 12, 1'b0, 1'b0);
    run(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 12, 1'b0, 1'b0);
    run(8'd7,   8'd9, 8'd0,   8'd7, 1'b0, 12, 1'b0, 1'b0);
    run(8'd0,   8'd4, 8'd0,   8'd0, 1'b0, 12, 1'b0, 1'b0);
    run(8'd100, 8'd10, 8'd10, 8'd0, 1'b0, 12, 1'b0, 1'b1);

    // Abort 200/7 with reset during cycle 5; outputs must clear and no Done may follow.
    A = 8'd200; B = 8'd7; Start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      Start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_q", Q, 0);
    check("abort_r", R, 0);
    check("abort_busy", Busy, 0);
    check("abort_done", Done, 0);
    check("abort_erro", Erro, 0);
    rst_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      check($sformatf("abort_idle_done c%0d", n), Done, 0);
      check($sformatf("abort_idle_busy c%0d", n), Busy, 0);
    end

    run(8'd17, 8'd4, 8'd4, 8'd1, 1'b0, 30, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("final_idle_busy", Busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
